// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment driver with per-slot blanking, leading-zero
// suppression and a 1-deep pending buffer that only reaches the display at frame boundaries.
module seg7_scan_mux #(
  parameter logic [15:0] SCAN_DIV     = 16'd10_000,
  parameter logic [15:0] BLANK_CYCLES = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        lz_blank_en,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t      state_reg, state_next;
  logic [15:0] slot_cnt_reg, slot_cnt_next;
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] disp_reg;
  logic [3:0]  dp_reg;
  logic [15:0] pend_digits_reg;
  logic [3:0]  pend_dp_reg;
  logic        pend_full_reg;

  logic [6:0]  seg_reg, seg_next;
  logic        dp_out_reg, dp_next;
  logic [3:0]  sel_reg, sel_next;
  logic        frame_done_reg;

  logic        slot_end;
  logic        frame_end;
  logic        xfer;
  logic [3:0]  cur_nib;
  logic [3:0]  lz_mask;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  assign slot_end   = (slot_cnt_reg == SCAN_DIV - 16'd1);
  assign frame_end  = (state_reg == SHOW) && slot_end && (idx_reg == 2'd3);
  assign load_ready = !pend_full_reg && !reset;
  assign xfer       = load_valid && load_ready;

  // Digit k is suppressed when it and every digit above it are zero; digit0 always shows.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_mask[gi] = 1'b0;
      end else begin : g_upper
        assign lz_mask[gi] = lz_blank_en && (disp_reg[15:4*gi] == '0);
      end
    end
  endgenerate

  assign cur_nib = disp_reg[{idx_reg, 2'b00} +: 4];

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    slot_cnt_next = slot_end ? 16'd0 : slot_cnt_reg + 16'd1;
    case (state_reg)
      BLANK: begin
        if (slot_cnt_reg == BLANK_CYCLES - 16'd1) state_next = SHOW;
      end
      SHOW: begin
        if (slot_end) begin
          state_next = BLANK;
          idx_next   = idx_reg + 2'd1;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  always_comb begin
    seg_next = 7'h00;
    dp_next  = 1'b0;
    sel_next = 4'b0000;
    if (state_reg == SHOW) begin
      sel_next = 4'b0001 << idx_reg;
      seg_next = lz_mask[idx_reg] ? 7'h00 : seg_decode(cur_nib);
      dp_next  = dp_reg[idx_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= BLANK;
      slot_cnt_reg    <= 16'd0;
      idx_reg         <= 2'd0;
      disp_reg        <= 16'd0;
      dp_reg          <= 4'd0;
      pend_digits_reg <= 16'd0;
      pend_dp_reg     <= 4'd0;
      pend_full_reg   <= 1'b0;
      seg_reg         <= 7'h00;
      dp_out_reg      <= 1'b0;
      sel_reg         <= 4'b0000;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      slot_cnt_reg <= slot_cnt_next;
      idx_reg      <= idx_next;
      // A full buffer blocks transfers, so the two branches never compete.
      if (frame_end && pend_full_reg) begin
        disp_reg      <= pend_digits_reg;
        dp_reg        <= pend_dp_reg;
        pend_full_reg <= 1'b0;
      end else if (xfer) begin
        pend_digits_reg <= digits_in;
        pend_dp_reg     <= dp_in;
        pend_full_reg   <= 1'b1;
      end
      seg_reg        <= seg_next;
      dp_out_reg     <= dp_next;
      sel_reg        <= sel_next;
      frame_done_reg <= frame_end;
    end
  end

  assign seg_out    = seg_reg;
  assign dp_out     = dp_out_reg;
  assign digit_sel  = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: per-cycle frame-position reference model,
// table-driven display vectors, hand-written corner sequences and random traffic.
module tb_seg7_scan_mux;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic        lz_blank_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.SCAN_DIV(16'(SD)), .BLANK_CYCLES(16'(BC))) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .load_valid(load_valid), .load_ready(load_ready), .lz_blank_en(lz_blank_en),
    .seg_out(seg_out), .dp_out(dp_out), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  // Reference state: m_p counts clock edges since reset, giving the position within the frame.
  int          m_p = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_dpr = '0, m_pdp = '0;
  bit          m_full = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_sel;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dps;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    int q, slot, c;
    logic [3:0] nib;
    bit xfer;
    if (reset) begin
      m_p = 0; m_disp = '0; m_dpr = '0; m_pend = '0; m_pdp = '0; m_full = 1'b0;
      e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fd = 1'b0;
    end else begin
      q = m_p % FRAME;
      slot = q / SD;
      c = q % SD;
      e_fd = (q == FRAME - 1);
      if (c >= BC) begin
        e_sel = 4'(1 << slot);
        nib = 4'(m_disp >> (4 * slot));
        e_seg = (lz_blank_en && slot > 0 && (m_disp >> (4 * slot)) == 16'h0) ? 7'h00 : ref_seg(nib);
        e_dp = m_dpr[slot];
      end else begin
        e_sel = '0; e_seg = '0; e_dp = 1'b0;
      end
      xfer = load_valid && !m_full;
      if (q == FRAME - 1 && m_full) begin
        m_disp = m_pend; m_dpr = m_pdp; m_full = 1'b0;
      end
      if (xfer) begin
        m_pend = digits_in; m_pdp = dp_in; m_full = 1'b1;
      end
      m_p++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("dp_out", 32'(dp_out), 32'(e_dp));
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("load_ready", 32'(load_ready), 32'(!m_full && !reset));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    bit done;
    done = 1'b0;
    digits_in = d; dp_in = p; load_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = load_ready;
      tick();
    end
    load_valid = 1'b0;
    chk("load_handshake", 32'(done), 32'd1);
  endtask

  // Run until the pending buffer has been moved into the display (a frame boundary).
  task automatic wait_drain();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (!load_ready) chk("ready_low_while_full", 32'(load_ready), 32'd0);
      tick();
      seen = load_ready;
    end
    chk("drain_ready", 32'(load_ready), 32'd1);
  endtask

  task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dps);
    int shows [4];
    int blanks;
    logic [3:0] one;
    segs = '0; dps = '0; blanks = 0;
    for (int j = 0; j < 4; j++) shows[j] = 0;
    for (int k = 0; k < 40 && (m_p % FRAME) != 0; k++) tick();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (digit_sel == 4'b0000) blanks++;
      for (int j = 0; j < 4; j++) begin
        one = 4'b0001 << j;
        if (digit_sel == one) begin
          segs[7*j +: 7] = seg_out;
          dps[j] = dp_out;
          shows[j]++;
        end
      end
    end
    for (int j = 0; j < 4; j++) chk("show_cycles_per_slot", 32'(shows[j]), 32'(SD - BC));
    chk("blank_cycles_per_frame", 32'(blanks), 32'(4 * BC));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] s;
    logic [3:0]  d;
    int last_fd, pulses;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
    vecs[1] = '{16'h0007, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, 4'b0000};
    vecs[2] = '{16'h0007, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'b0000};
    vecs[3] = '{16'hA000, 4'b1000, 1'b0, {7'h40, 7'h3F, 7'h3F, 7'h3F}, 4'b1000};
    vecs[4] = '{16'h0105, 4'b0101, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h6D}, 4'b0101};
    vecs[5] = '{16'h5F68, 4'b0110, 1'b0, {7'h6D, 7'h40, 7'h7D, 7'h7F}, 4'b0110};
    vecs[6] = '{16'h0000, 4'b0001, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001};

    reset = 1'b1; load_valid = 1'b0; digits_in = '0; dp_in = '0; lz_blank_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      lz_blank_en = vecs[v].lz;
      load(vecs[v].digits, vecs[v].dp);
      wait_drain();
      capture_frame(s, d);
      chk("vec_segs", 32'(s), 32'(vecs[v].segs));
      chk("vec_dps", 32'(d), 32'(vecs[v].dps));
      $display("vector %0d: digits=%h dp=%b lz=%0d segs=%h", v, vecs[v].digits, vecs[v].dp, vecs[v].lz, s);
    end

    // Back-to-back loads: the second waits in the buffer until the next boundary.
    lz_blank_en = 1'b0;
    load(16'h1111, 4'b0000);
    digits_in = 16'h2222; load_valid = 1'b1;
    wait_drain();
    capture_frame(s, d);
    chk("b2b_first_frame", 32'(s), 32'({7'h06, 7'h06, 7'h06, 7'h06}));
    load_valid = 1'b0;
    capture_frame(s, d);
    chk("b2b_second_frame", 32'(s), 32'({7'h5B, 7'h5B, 7'h5B, 7'h5B}));
    $display("back-to-back: second frame segs=%h", s);

    // Reset during SHOW of digit2 while the buffer holds an undisplayed value.
    load(16'h1234, 4'b1111);
    wait_drain();
    load(16'h9999, 4'b1111);
    for (int k = 0; k < 40 && (m_p % FRAME) != 2 * SD + 4; k++) tick();
    chk("pre_reset_sel_digit2", 32'(digit_sel), 32'(4'b0100));
    reset = 1'b1;
    tick();
    chk("reset_seg", 32'(seg_out), 32'd0);
    chk("reset_sel", 32'(digit_sel), 32'd0);
    chk("reset_dp", 32'(dp_out), 32'd0);
    chk("reset_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    capture_frame(s, d);
    chk("post_reset_segs", 32'(s), 32'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
    chk("post_reset_dps", 32'(d), 32'd0);
    chk("post_reset_ready", 32'(load_ready), 32'd1);
    $display("reset mid-show: post-reset segs=%h dps=%b", s, d);

    // Free-running frame_done period.
    last_fd = -1; pulses = 0;
    for (int k = 0; k < 4 * FRAME + 4; k++) begin
      tick();
      if (frame_done) begin
        if (last_fd >= 0) chk("frame_done_period", 32'(cyc - last_fd), 32'(FRAME));
        last_fd = cyc;
        pulses++;
      end
    end
    chk("frame_done_pulses", 32'(pulses), 32'd4);
    $display("free run: %0d frame_done pulses", pulses);

    // Random traffic against the reference model.
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 4; j++)
        digits_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lz_blank_en = ~lz_blank_en;
      tick();
    end
    reset = 1'b0; load_valid = 1'b0;
    tick();
    $display("random: 1500 cycles applied");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
